lifo_reverse_controller: RTL

//  Stream front-end/back-end that drives the 8-bit LIFO stack's Push/Pop/Peek port.

---
 rtl/lifo_reverse_controller_if.sv | 48 ++++
 rtl/lifo_reverse_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/lifo_reverse_controller_if.sv
// ---------------------------------------------------------------------------
// lifo_reverse_controller_if
// Bundles the three byte-wide links of the LIFO reverse controller:
//   In_*    : upstream valid/ready byte stream with frame marker
//   Out_*   : downstream valid/ready byte stream (reversed order)
//   Stack_* : Push/Pop/Peek port of the external 8-bit LIFO stack
// modport master : the controller side
// modport slave  : the surrounding environment (source, sink and stack)
// ---------------------------------------------------------------------------
interface lifo_reverse_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] In_Data;
    logic                  In_Valid;
    logic                  In_Last;
    logic                  In_Ready;

    logic [DATA_WIDTH-1:0] Out_Data;
    logic                  Out_Valid;
    logic                  Out_Last;
    logic                  Out_Ready;

    logic [DATA_WIDTH-1:0] Stack_Data_Out;
    logic                  Stack_Push_Out;
    logic                  Stack_Pop_Out;
    logic                  Stack_Peek_Out;
    logic [DATA_WIDTH-1:0] Stack_Data_In;
    logic                  Stack_Empty_In;
    logic                  Stack_Full_In;

    modport master (
        input  In_Data, In_Valid, In_Last,
        output In_Ready,
        output Out_Data, Out_Valid, Out_Last,
        input  Out_Ready,
        output Stack_Data_Out, Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out,
        input  Stack_Data_In, Stack_Empty_In, Stack_Full_In
    );

    modport slave (
        output In_Data, In_Valid, In_Last,
        input  In_Ready,
        input  Out_Data, Out_Valid, Out_Last,
        output Out_Ready,
        input  Stack_Data_Out, Stack_Push_Out, Stack_Pop_Out, Stack_Peek_Out,
        output Stack_Data_In, Stack_Empty_In, Stack_Full_In
    );
endinterface

// File: rtl/lifo_reverse_controller.sv
// ---------------------------------------------------------------------------
// lifo_reverse_controller
// Pushes an incoming byte stream into an external LIFO stack and, on frame
// end or stack full, drains it with Peek+Pop pairs so the bytes leave in
// reverse order on a registered valid/ready output stream.
// Ports:
//   Clk_In         : single clock, rising edge
//   Reset_In       : asynchronous active-low reset (also resets the stack)
//   ctl            : In_*/Out_*/Stack_* links (interface, master side)
//   Sync_Error_Out : sticky flag, stack reported empty while bytes were owed
// ---------------------------------------------------------------------------
module lifo_reverse_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                        Clk_In,
    input  logic                        Reset_In,
    lifo_reverse_controller_if.master   ctl,
    output logic                        Sync_Error_Out
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PEEK = 2'd1;
    localparam logic [1:0] ST_POP  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic [CW-1:0]         fill_q,      fill_d;
    logic                  frame_end_q, frame_end_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;
    logic                  sync_err_q,  sync_err_d;

    logic                  in_ready;
    logic                  accept;
    logic [CW-1:0]         fill_inc;

    // In_Ready is gated by reset so no push strobe can escape while the
    // stack is being held in reset.
    assign in_ready = Reset_In && (state_q == ST_FILL) &&
                      (fill_q < CW'(DEPTH)) && !ctl.Stack_Full_In;
    assign accept   = ctl.In_Valid && in_ready;
    assign fill_inc = fill_q + CW'(1);

    assign ctl.In_Ready       = in_ready;
    assign ctl.Stack_Data_Out = ctl.In_Data;
    // Strobes are decoded from disjoint conditions, so at most one is high.
    assign ctl.Stack_Push_Out = accept;
    assign ctl.Stack_Peek_Out = (state_q == ST_PEEK);
    assign ctl.Stack_Pop_Out  = (state_q == ST_POP);

    assign ctl.Out_Data   = out_data_q;
    assign ctl.Out_Valid  = out_valid_q;
    assign ctl.Out_Last   = out_last_q;
    assign Sync_Error_Out = sync_err_q;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        frame_end_d = frame_end_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sync_err_d  = sync_err_q;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    fill_d = fill_inc;
                    if (ctl.In_Last || (fill_inc == CW'(DEPTH))) begin
                        state_d     = ST_PEEK;
                        frame_end_d = ctl.In_Last;
                    end
                end
            end
            ST_PEEK: begin
                // Stack disagrees with our count: abandon the chunk.
                if (ctl.Stack_Empty_In) begin
                    sync_err_d  = 1'b1;
                    fill_d      = '0;
                    frame_end_d = 1'b0;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                // Stack_Data_In carries the value latched by the previous Peek.
                out_data_d  = ctl.Stack_Data_In;
                out_valid_d = 1'b1;
                out_last_d  = frame_end_q && (fill_q == CW'(1));
                fill_d      = fill_q - CW'(1);
                state_d     = ST_HOLD;
            end
            default: begin // ST_HOLD
                if (ctl.Out_Ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (fill_q == '0) begin
                        state_d     = ST_FILL;
                        frame_end_d = 1'b0;
                    end else begin
                        state_d = ST_PEEK;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q     <= ST_FILL;
            fill_q      <= '0;
            frame_end_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            frame_end_q <= frame_end_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sync_err_q  <= sync_err_d;
        end
    end
endmodule
